sync_multi_fifo: RTL and testbench

- Single-clock, multi-channel FIFO for switch-side queuing, e.g. per-output-port queues in the gsm_4x4 fabric.
- NUM_CH = 2**CBITWIDTH logical queues share one distributed-RAM array; each queue has its own fixed partition of 2**ABITWIDTH entries.
- Per cycle: at most one write and one read, to any channels, including the same one.
- Generalises the existing FIFO: channel count, optional output register, per-channel flush, sticky overflow/underflow errors.

---
 rtl/sync_multi_fifo.sv | 123 ++++++++++++
 tb/tb_sync_multi_fifo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_multi_fifo.sv
// rtl/sync_multi_fifo.sv - single-clock multi-channel FIFO sharing one partitioned RAM
module sync_multi_fifo #(
    parameter int DBITWIDTH    = 32,
    parameter int ABITWIDTH    = 4,
    parameter int CBITWIDTH    = 2,
    parameter int AF_THRESHOLD = 4,
    parameter int DOUT_REG     = 0
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic [2**CBITWIDTH-1:0]   flush,
    input  logic                      write,
    input  logic [CBITWIDTH-1:0]      wr_ch,
    input  logic [DBITWIDTH-1:0]      write_data,
    input  logic                      read,
    input  logic [CBITWIDTH-1:0]      rd_ch,
    output logic [DBITWIDTH-1:0]      read_data,
    output logic                      rd_valid,
    output logic [2**CBITWIDTH-1:0]   empty,
    output logic [2**CBITWIDTH-1:0]   almost_full,
    output logic [2**CBITWIDTH-1:0]   full,
    output logic                      ovf_err,
    output logic                      unf_err
);
    localparam int NUM_CH = 2**CBITWIDTH;
    localparam int DEPTH  = 2**ABITWIDTH;
    localparam logic [ABITWIDTH:0] AF_LEVEL = (ABITWIDTH+1)'(DEPTH - AF_THRESHOLD);

    logic [DBITWIDTH-1:0] mem_q [2**(CBITWIDTH+ABITWIDTH)];
    logic [ABITWIDTH-1:0] wr_ptr_q [NUM_CH];
    logic [ABITWIDTH-1:0] wr_ptr_d [NUM_CH];
    logic [ABITWIDTH-1:0] rd_ptr_q [NUM_CH];
    logic [ABITWIDTH-1:0] rd_ptr_d [NUM_CH];
    logic [ABITWIDTH:0]   cnt_q    [NUM_CH];
    logic [ABITWIDTH:0]   cnt_d    [NUM_CH];
    logic                 ovf_q, unf_q;
    logic                 wr_acc, rd_acc, wr_rej, rd_rej;
    logic [NUM_CH-1:0]    w_hit, r_hit;
    logic [DBITWIDTH-1:0] head_data;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            empty[c]       = (cnt_q[c] == '0);
            full[c]        = cnt_q[c][ABITWIDTH];
            almost_full[c] = (cnt_q[c] >= AF_LEVEL);
        end
    end

    // A flushed channel swallows its traffic silently, so it neither accepts nor errors.
    assign wr_acc = write & ~clr & ~full[wr_ch]  & ~flush[wr_ch];
    assign rd_acc = read  & ~clr & ~empty[rd_ch] & ~flush[rd_ch];
    assign wr_rej = write & ~clr &  full[wr_ch]  & ~flush[wr_ch];
    assign rd_rej = read  & ~clr &  empty[rd_ch] & ~flush[rd_ch];

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_hit[c]    = wr_acc & (wr_ch == CBITWIDTH'(c));
            r_hit[c]    = rd_acc & (rd_ch == CBITWIDTH'(c));
            wr_ptr_d[c] = wr_ptr_q[c] + ABITWIDTH'(w_hit[c]);
            rd_ptr_d[c] = rd_ptr_q[c] + ABITWIDTH'(r_hit[c]);
            cnt_d[c]    = cnt_q[c] + (ABITWIDTH+1)'(w_hit[c]) - (ABITWIDTH+1)'(r_hit[c]);
            if (flush[c]) begin
                wr_ptr_d[c] = '0;
                rd_ptr_d[c] = '0;
                cnt_d[c]    = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                cnt_q[c]    <= cnt_d[c];
            end
            ovf_q <= ovf_q | wr_rej;
            unf_q <= unf_q | rd_rej;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[{wr_ch, wr_ptr_q[wr_ch]}] <= write_data;
        end
    end

    // Head lookup reads the pre-edge RAM, so a same-channel write never bypasses.
    assign head_data = mem_q[{rd_ch, rd_ptr_q[rd_ch]}];
    assign ovf_err   = ovf_q;
    assign unf_err   = unf_q;

    generate
        if (DOUT_REG != 0) begin : g_dout_reg
            logic [DBITWIDTH-1:0] rdata_q;
            logic                 rvalid_q;
            always_ff @(posedge clk) begin
                if (clr) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_acc;
                    if (rd_acc) begin
                        rdata_q <= head_data;
                    end
                end
            end
            assign read_data = rdata_q;
            assign rd_valid  = rvalid_q;
        end else begin : g_dout_comb
            assign read_data = head_data;
            assign rd_valid  = rd_acc;
        end
    endgenerate
endmodule

// File: tb/tb_sync_multi_fifo.sv
// tb/tb_sync_multi_fifo.sv - bench for sync_multi_fifo, combinational and registered read variants
module tb_sync_multi_fifo;
    localparam int NCH   = 4;
    localparam int DEPTH = 16;
    localparam int AFT   = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr = 1'b1, write = 1'b0, read = 1'b0;
    logic [3:0]  flush = 4'b0;
    logic [1:0]  wr_ch = 2'd0, rd_ch = 2'd0;
    logic [31:0] write_data = 32'd0;

    logic [31:0] read_data, read_data_r;
    logic        rd_valid, rd_valid_r;
    logic [3:0]  empty, almost_full, full, empty_r, almost_full_r, full_r;
    logic        ovf_err, unf_err, ovf_err_r, unf_err_r;

    sync_multi_fifo #(.DBITWIDTH(32), .ABITWIDTH(4), .CBITWIDTH(2), .AF_THRESHOLD(AFT), .DOUT_REG(0)) u_dut (
        .clk(clk), .clr(clr), .flush(flush), .write(write), .wr_ch(wr_ch), .write_data(write_data),
        .read(read), .rd_ch(rd_ch), .read_data(read_data), .rd_valid(rd_valid), .empty(empty),
        .almost_full(almost_full), .full(full), .ovf_err(ovf_err), .unf_err(unf_err));

    sync_multi_fifo #(.DBITWIDTH(32), .ABITWIDTH(4), .CBITWIDTH(2), .AF_THRESHOLD(AFT), .DOUT_REG(1)) u_dut_reg (
        .clk(clk), .clr(clr), .flush(flush), .write(write), .wr_ch(wr_ch), .write_data(write_data),
        .read(read), .rd_ch(rd_ch), .read_data(read_data_r), .rd_valid(rd_valid_r), .empty(empty_r),
        .almost_full(almost_full_r), .full(full_r), .ovf_err(ovf_err_r), .unf_err(unf_err_r));

    int checks = 0;
    int errors = 0;

    // Reference: one queue per channel plus sticky error bits and the registered-output shadow.
    logic [31:0] mq [NCH][$];
    logic        m_ovf = 1'b0, m_unf = 1'b0, m_prev_rv = 1'b0;
    logic [31:0] m_held = 32'd0;

    logic        d_rv;
    logic [31:0] d_rd;
    logic [3:0]  d_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic c, input logic [3:0] fl, input logic w, input logic [1:0] wc,
                        input logic [31:0] wd, input logic r, input logic [1:0] rc,
                        output logic o_rv, output logic [31:0] o_rd, output logic [3:0] o_empty);
        logic [3:0] e_empty, e_full, e_af;
        logic       wacc, racc;
        @(negedge clk);
        clr = c; flush = fl; write = w; wr_ch = wc; write_data = wd; read = r; rd_ch = rc;
        #1;
        for (int i = 0; i < NCH; i++) begin
            e_empty[i] = (mq[i].size() == 0);
            e_full[i]  = (mq[i].size() == DEPTH);
            e_af[i]    = ((DEPTH - mq[i].size()) <= AFT);
        end
        wacc = w && !c && !fl[wc] && (mq[wc].size() < DEPTH);
        racc = r && !c && !fl[rc] && (mq[rc].size() > 0);
        check("empty", empty, e_empty);
        check("full", full, e_full);
        check("almost_full", almost_full, e_af);
        check("ovf_err", ovf_err, m_ovf);
        check("unf_err", unf_err, m_unf);
        check("rd_valid", rd_valid, racc);
        if (racc) check("read_data", read_data, mq[rc][0]);
        check("reg_rd_valid", rd_valid_r, m_prev_rv);
        check("reg_read_data", read_data_r, m_held);
        o_rv = rd_valid; o_rd = read_data; o_empty = empty;
        if (c) begin
            for (int i = 0; i < NCH; i++) mq[i].delete();
            m_ovf = 1'b0; m_unf = 1'b0; m_prev_rv = 1'b0; m_held = 32'd0;
        end else begin
            if (w && !fl[wc] && !wacc) m_ovf = 1'b1;
            if (r && !fl[rc] && !racc) m_unf = 1'b1;
            m_prev_rv = racc;
            if (racc) m_held = mq[rc].pop_front();
            if (wacc) mq[wc].push_back(wd);
            for (int i = 0; i < NCH; i++) if (fl[i]) mq[i].delete();
        end
        @(posedge clk);
    endtask

    task automatic rst();
        step(1'b1, 4'b0, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, d_rv, d_rd, d_e);
    endtask
    task automatic wr(input logic [1:0] ch, input logic [31:0] d);
        step(1'b0, 4'b0, 1'b1, ch, d, 1'b0, 2'd0, d_rv, d_rd, d_e);
    endtask
    task automatic rd(input logic [1:0] ch);
        step(1'b0, 4'b0, 1'b0, 2'd0, 32'd0, 1'b1, ch, d_rv, d_rd, d_e);
    endtask

    typedef struct {
        logic        c;
        logic        w;
        logic [1:0]  wc;
        logic [31:0] wd;
        logic        r;
        logic [1:0]  rc;
        logic        e_rv;
        logic [31:0] e_rd;
        logic [3:0]  e_empty;
    } vec_t;
    vec_t vt[10];

    initial begin
        vt[0] = '{1'b1, 1'b0, 2'd0, 32'h0,  1'b0, 2'd0, 1'b0, 32'h0,  4'b1111};
        vt[1] = '{1'b0, 1'b1, 2'd2, 32'hA0, 1'b0, 2'd0, 1'b0, 32'h0,  4'b1111};
        vt[2] = '{1'b0, 1'b1, 2'd2, 32'hA1, 1'b0, 2'd0, 1'b0, 32'h0,  4'b1011};
        vt[3] = '{1'b0, 1'b1, 2'd2, 32'hA2, 1'b0, 2'd0, 1'b0, 32'h0,  4'b1011};
        vt[4] = '{1'b0, 1'b1, 2'd2, 32'hA3, 1'b0, 2'd0, 1'b0, 32'h0,  4'b1011};
        vt[5] = '{1'b0, 1'b0, 2'd0, 32'h0,  1'b1, 2'd2, 1'b1, 32'hA0, 4'b1011};
        vt[6] = '{1'b0, 1'b0, 2'd0, 32'h0,  1'b1, 2'd2, 1'b1, 32'hA1, 4'b1011};
        vt[7] = '{1'b0, 1'b0, 2'd0, 32'h0,  1'b1, 2'd2, 1'b1, 32'hA2, 4'b1011};
        vt[8] = '{1'b0, 1'b0, 2'd0, 32'h0,  1'b1, 2'd2, 1'b1, 32'hA3, 4'b1011};
        vt[9] = '{1'b0, 1'b0, 2'd0, 32'h0,  1'b0, 2'd0, 1'b0, 32'h0,  4'b1111};

        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            step(vt[i].c, 4'b0, vt[i].w, vt[i].wc, vt[i].wd, vt[i].r, vt[i].rc, d_rv, d_rd, d_e);
            check("tv_rd_valid", d_rv, vt[i].e_rv);
            if (vt[i].e_rv) check("tv_read_data", d_rd, vt[i].e_rd);
            check("tv_empty", d_e, vt[i].e_empty);
        end

        // Fill ch0 past capacity: almost_full on 12th, full on 16th, 17th dropped.
        rst();
        for (int k = 0; k < 16; k++) begin
            wr(2'd0, 32'hB00 + k);
            #1;
            if (k == 10) check("af_after_11", almost_full[0], 1'b0);
            if (k == 11) check("af_after_12", almost_full[0], 1'b1);
            if (k == 14) check("full_after_15", full[0], 1'b0);
        end
        #1 check("full_after_16", full[0], 1'b1);
        wr(2'd0, 32'hDEAD);
        #1 check("ovf_after_17", ovf_err, 1'b1);
        for (int k = 0; k < 16; k++) rd(2'd0);
        #1 check("ch0_drained", empty[0], 1'b1);

        // Read of empty ch1 with same-cycle write: read rejected, write kept.
        rst();
        step(1'b0, 4'b0, 1'b1, 2'd1, 32'h55, 1'b1, 2'd1, d_rv, d_rd, d_e);
        check("nobypass_rv", d_rv, 1'b0);
        #1 check("nobypass_unf", unf_err, 1'b1);
        step(1'b0, 4'b0, 1'b0, 2'd0, 32'h0, 1'b1, 2'd1, d_rv, d_rd, d_e);
        check("nobypass_rd", d_rd, 32'h55);

        // Full ch3, write+read same cycle: read serviced, write rejected.
        rst();
        for (int k = 0; k < 16; k++) wr(2'd3, 32'h300 + k);
        step(1'b0, 4'b0, 1'b1, 2'd3, 32'h77, 1'b1, 2'd3, d_rv, d_rd, d_e);
        check("full_rw_rd", d_rd, 32'h300);
        #1;
        check("full_rw_ovf", ovf_err, 1'b1);
        check("full_rw_notfull", full[3], 1'b0);
        for (int k = 0; k < 15; k++) rd(2'd3);

        // Flush one channel, the neighbour keeps its data; then pointer wrap.
        rst();
        for (int k = 0; k < 3; k++) begin wr(2'd0, 32'hC0 + k); wr(2'd1, 32'hD0 + k); end
        step(1'b0, 4'b0001, 1'b1, 2'd0, 32'hEE, 1'b1, 2'd0, d_rv, d_rd, d_e);
        #1 check("flush_empty0", empty[0], 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 4'b0, 1'b0, 2'd0, 32'h0, 1'b1, 2'd1, d_rv, d_rd, d_e);
            check("flush_ch1_data", d_rd, 32'hD0 + k);
        end
        wr(2'd2, 32'h1000);
        for (int k = 1; k <= 40; k++)
            step(1'b0, 4'b0, 1'b1, 2'd2, 32'h1000 + k, 1'b1, 2'd2, d_rv, d_rd, d_e);

        // Registered variant: clr right after an accepted read wipes the output register.
        wr(2'd0, 32'hF00D);
        rd(2'd0);
        #1;
        check("reg_rv_next", rd_valid_r, 1'b1);
        check("reg_rd_next", read_data_r, 32'hF00D);
        rst();
        #1;
        check("reg_clr_rv", rd_valid_r, 1'b0);
        check("reg_clr_rd", read_data_r, 32'h0);
        check("clr_empty", empty, 4'b1111);

        // Random traffic against the queue model.
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0,
                 ($urandom_range(0, 99) < 60), 2'($urandom), $urandom,
                 ($urandom_range(0, 99) < 50), 2'($urandom),
                 d_rv, d_rd, d_e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end
endmodule
